sinc_decimator: RTL and testbench
=================================

Name: sinc_decimator

Overview:
- Multi-channel CIC (sinc^ORDER) decimator for 1-bit sigma-delta bitstreams.
- Runtime-selectable power-of-two ratio R = 2^log2_r.
- Normalised, saturated unsigned output per channel with a valid/ready handshake and a sticky overrun flag.
- Sits between the modulator bitstream outputs and the downstream sample consumer (DSP/register bank).
- Generalises the single-channel sinc1 ones-counter to N channels, higher order and backpressure.

Parameters:
- CHANNELS, 2, number of independent bitstream channels (>=1).
- ORDER, 3, CIC order (1..4).
- MAX_LOG2_R, 8, largest supported log2 of decimation ratio (>=1).
- OUT_W, 16, output word width per channel. Constraint: ORDER*MAX_LOG2_R >= OUT_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  advance filter one input sample per cycle when high.
- log2_r  in  4  requested log2 ratio; clamped to 1..MAX_LOG2_R; applied only while en low.
- stream_in  in  CHANNELS  one bitstream bit per channel; bit i = channel i.
- dout  out  CHANNELS*OUT_W  channel i in bits [i*OUT_W +: OUT_W].
- dout_valid  out  1  dout holds an unconsumed sample.
- dout_ready  in  1  consumer accepts dout when high with dout_valid.
- overrun  out  1  sticky: an unconsumed sample was overwritten.

Behaviour:
- Reset (rst_n low at edge) clears all state:
  - integrators, comb delays, phase counter, settle counter, dout, dout_valid, overrun all 0.
  - r_q <= clamp(log2_r); clamp maps 0 to 1 and values >MAX_LOG2_R to MAX_LOG2_R.
- Accumulators: W = ORDER*MAX_LOG2_R+1 bits, unsigned modulo-2^W. Integrator wrap is intended; comb differences recover the exact result. Input bit contributes 0 or 1.
- en high, per cycle:
  - Integrator 1 adds stream_in; integrator k adds integrator k-1 (cascade, ORDER stages).
  - Phase counter increments 0..2^r_q-1, then wraps.
- Decimation tick: the edge where phase==2^r_q-1 and en high. That edge's sample is included in the window.
- Following edge:
  - Comb chain (ORDER differences vs. previous decimated value) is evaluated and the comb delay registers are updated.
  - Output stage loads, so latency = 2 edges from the window's last input sample to dout update.
- Window result is in 0..2^(ORDER*r_q).
- Normalisation: norm = result << (ORDER*(MAX_LOG2_R-r_q)); out = norm >> (ORDER*MAX_LOG2_R-OUT_W), saturated to 2^OUT_W-1. Full-scale ones therefore yields all-ones, never 0.
- Settling: the first ORDER comb outputs after reset/flush are discarded (no dout load, no valid). The settle counter saturates at ORDER.
- Handshake:
  - dout_valid rises when a settled sample loads and holds until an edge with dout_ready high.
  - dout stays stable while valid and not accepted.
  - dout_ready while dout_valid low has no effect.
- Simultaneous accept and new load on the same edge: new sample loads, dout_valid stays 1, no overrun.
- New load while dout_valid=1 and dout_ready=0: dout overwritten, dout_valid stays 1, overrun <= 1. overrun clears only on reset.
- en low:
  - Filter frozen; stream_in ignored.
  - Output handshake continues normally.
  - Each cycle r_q <= clamp(log2_r). If the value differs from the current r_q, flush: integrators, combs, phase and settle counters cleared. dout, dout_valid and overrun are untouched.
- en high: log2_r changes are ignored.
- Reset mid-window: discards the partial window; the full settle sequence restarts.

Test Plan:
- Defaults, log2_r=4, en=1, stream_in=2'b11, dout_ready=1 -> first 3 windows produce no valid. Then dout_valid pulses 1 cycle every 16 cycles with both channels 16'hFFFF.
- log2_r=4, ch0 alternating 1,0 and ch1 constant 0, ready=1 -> settled samples ch0=16'h8000, ch1=16'h0000.
- Settled stream, dout_ready=0 for 2 windows -> dout frozen for the first window, overwritten at the second load, overrun=1. Then ready=1 -> valid drops next edge; overrun stays 1 until rst_n low.
- ready asserted on the exact edge of a new load -> dout takes new value, dout_valid stays 1, overrun stays 0.
- en low, log2_r 4->2, en high, ones input -> flush, 3 discarded windows of 4 cycles, then 16'hFFFF every 4 cycles. log2_r=0 -> behaves as 1; log2_r=15 -> behaves as 8.
- rst_n low mid-window with dout_valid=1 -> next edge dout=0, dout_valid=0, overrun=0, full settle restarts.

Source files
------------

// File: rtl/sinc_decimator.sv
// Multi-channel CIC (sinc^ORDER) decimator for 1-bit sigma-delta bitstreams.
// Runtime power-of-two ratio, normalised saturated output, valid/ready handshake
// with a sticky overrun flag.
module sinc_decimator #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned ORDER      = 3,
  parameter int unsigned MAX_LOG2_R = 8,
  parameter int unsigned OUT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [3:0]                log2_r,
  input  logic [CHANNELS-1:0]       stream_in,
  output logic [CHANNELS*OUT_W-1:0] dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      overrun
);

  localparam int unsigned AccW      = ORDER * MAX_LOG2_R + 1;
  localparam int unsigned PhW       = MAX_LOG2_R;
  localparam int unsigned SetW      = $clog2(ORDER + 1);
  localparam int unsigned NormShift = ORDER * MAX_LOG2_R - OUT_W;

  typedef logic [AccW-1:0] acc_t;

  localparam logic [PhW:0]    PhOne     = 1;
  localparam logic [SetW-1:0] SettleMax = SetW'(ORDER);

  // Map the requested ratio onto the supported range 1..MAX_LOG2_R.
  function automatic logic [3:0] clamp_r(input logic [3:0] v);
    if (v == 4'd0) return 4'd1;
    if ({28'd0, v} > MAX_LOG2_R) return 4'(MAX_LOG2_R);
    return v;
  endfunction

  // Scale a window result so full scale lands at the top of the output word.
  function automatic logic [OUT_W-1:0] normalise(input acc_t res, input logic [3:0] r);
    acc_t norm;
    acc_t scaled;
    norm   = res << (ORDER * (MAX_LOG2_R - {28'd0, r}));
    scaled = norm >> NormShift;
    // Only an all-ones window reaches 2^OUT_W; clip it instead of wrapping to 0.
    if (scaled > acc_t'({OUT_W{1'b1}})) return '1;
    return scaled[OUT_W-1:0];
  endfunction

  acc_t int_q   [CHANNELS][ORDER];
  acc_t int_d   [CHANNELS][ORDER];
  acc_t comb_q  [CHANNELS][ORDER];
  acc_t comb_d  [CHANNELS][ORDER];
  // comb_in[c][k] feeds comb stage k; comb_in[c][ORDER] is the window result.
  acc_t comb_in [CHANNELS][ORDER+1];

  logic [PhW-1:0]            phase_q, phase_d;
  logic [SetW-1:0]           settle_q, settle_d;
  logic [3:0]                r_q, r_d, r_req;
  logic                      tick_q, tick_d;
  logic [CHANNELS*OUT_W-1:0] dout_q, dout_d, norm_out;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic [PhW:0]              phase_mask;
  logic                      phase_last, flush, comb_eval, settled, load;

  // Sequencing: phase counter, decimation tick, settle count, ratio and flush.
  always_comb begin
    r_req      = clamp_r(log2_r);
    phase_mask = (PhOne << r_q) - PhOne;
    phase_last = ({1'b0, phase_q} == phase_mask);
    flush      = !en && (r_req != r_q);
    // The comb runs on the edge after a tick, even if en has since dropped.
    comb_eval  = tick_q && !flush;
    settled    = (settle_q == SettleMax);
    load       = comb_eval && settled;

    r_d      = en ? r_q : r_req;
    phase_d  = phase_q;
    tick_d   = 1'b0;
    settle_d = settle_q;
    if (en) begin
      phase_d = phase_last ? '0 : phase_q + PhW'(1);
      tick_d  = phase_last;
    end
    if (comb_eval && !settled) begin
      settle_d = settle_q + SetW'(1);
    end
    if (flush) begin
      phase_d  = '0;
      tick_d   = 1'b0;
      settle_d = '0;
    end
  end

  // Datapath: integrator cascade, comb chain and per-channel normalisation.
  always_comb begin
    acc_t carry;
    acc_t sum;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      carry = acc_t'(stream_in[c]);
      for (int k = 0; k < int'(ORDER); k++) begin
        sum          = int_q[c][k] + carry;
        carry        = sum;
        int_d[c][k]  = flush ? '0 : (en ? sum : int_q[c][k]);
      end
      // Modulo-2^AccW differences recover the exact result despite wrap.
      comb_in[c][0] = int_q[c][ORDER-1];
      for (int k = 0; k < int'(ORDER); k++) begin
        comb_in[c][k+1] = comb_in[c][k] - comb_q[c][k];
        comb_d[c][k]    = flush ? '0 : (comb_eval ? comb_in[c][k] : comb_q[c][k]);
      end
      norm_out[c*OUT_W +: OUT_W] = normalise(comb_in[c][ORDER], r_q);
    end
  end

  // Output stage: load settled samples, handshake, sticky overrun.
  always_comb begin
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      dout_d  = norm_out;
      valid_d = 1'b1;
      if (valid_q && !dout_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        for (int k = 0; k < int'(ORDER); k++) begin
          int_q[c][k]  <= '0;
          comb_q[c][k] <= '0;
        end
      end
      phase_q   <= '0;
      settle_q  <= '0;
      tick_q    <= 1'b0;
      r_q       <= r_req;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        for (int k = 0; k < int'(ORDER); k++) begin
          int_q[c][k]  <= int_d[c][k];
          comb_q[c][k] <= comb_d[c][k];
        end
      end
      phase_q   <= phase_d;
      settle_q  <= settle_d;
      tick_q    <= tick_d;
      r_q       <= r_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sinc_decimator.sv
// Self-checking bench for sinc_decimator. A reference model computes each
// window as a direct FIR with the CIC impulse response and pushes the expected
// sample into a queue; the load edge pops it into the expected output stage.
module tb_sinc_decimator;

  localparam int CH   = 2;
  localparam int ORD  = 3;
  localparam int MAXL = 8;
  localparam int OW   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [3:0]    log2_r;
  logic [CH-1:0] stream_in;
  logic [31:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          overrun;

  always #5 clk = ~clk;

  sinc_decimator #(
    .CHANNELS  (CH),
    .ORDER     (ORD),
    .MAX_LOG2_R(MAXL),
    .OUT_W     (OW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .log2_r    (log2_r),
    .stream_in (stream_in),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overrun   (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_r;
  int          m_phase;
  int          m_win;
  bit          m_pend;
  bit          m_valid;
  bit          m_ovr;
  logic [31:0] m_dout;
  bit          x0[$];
  bit          x1[$];
  longint      hc[$];
  logic [31:0] exp_q[$];

  function automatic int clampr(input int v);
    if (v == 0) return 1;
    if (v > MAXL) return MAXL;
    return v;
  endfunction

  // Impulse response of (1 + z^-1 + ... + z^-(R-1))^ORDER.
  task automatic build_h();
    longint nxt[$];
    longint s;
    int     rr;
    rr = 1 << m_r;
    hc = {};
    hc.push_back(64'd1);
    repeat (ORD) begin
      nxt = {};
      for (int j = 0; j < hc.size() + rr - 1; j++) begin
        s = 0;
        for (int k = 0; k < rr; k++) begin
          if (j - k >= 0 && j - k < hc.size()) s += hc[j-k];
        end
        nxt.push_back(s);
      end
      hc = nxt;
    end
  endtask

  function automatic logic [15:0] win_out(input int ch);
    longint acc;
    longint v;
    int     e;
    e   = x0.size() - 1;
    acc = 0;
    for (int k = 0; k < hc.size() && e - k >= 0; k++) begin
      if ((ch == 0) ? x0[e-k] : x1[e-k]) acc += hc[k];
    end
    v = (acc << (ORD * (MAXL - m_r))) >> (ORD * MAXL - OW);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  task automatic model_clear();
    x0      = {};
    x1      = {};
    m_phase = 0;
    m_win   = 0;
    m_pend  = 1'b0;
    build_h();
  endtask

  // Drive one cycle of inputs, advance the model for the coming edge, then
  // step to just after that edge.
  task automatic cycle(input logic e, input logic [1:0] b, input logic rdy);
    bit ld;
    en         = e;
    stream_in  = b;
    dout_ready = rdy;
    if (!rst_n) begin
      m_r     = clampr(int'(log2_r));
      model_clear();
      exp_q   = {};
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_dout  = '0;
    end else begin
      ld     = m_pend;
      m_pend = 1'b0;
      if (!e) begin
        if (clampr(int'(log2_r)) != m_r) begin
          m_r = clampr(int'(log2_r));
          model_clear();
          exp_q = {};
          ld    = 1'b0;
        end
      end else begin
        x0.push_back(b[0]);
        x1.push_back(b[1]);
        if (m_phase == (1 << m_r) - 1) begin
          m_phase = 0;
          if (m_win >= ORD) begin
            exp_q.push_back({win_out(1), win_out(0)});
            m_pend = 1'b1;
          end
          m_win++;
        end else begin
          m_phase++;
        end
      end
      if (ld) begin
        if (m_valid && !rdy) m_ovr = 1'b1;
        m_dout  = exp_q.pop_front();
        m_valid = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst_n  = 1'b0;
    log2_r = r;
    cycle(1'b1, 2'b00, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    log2_r = 4'd4;
    cycle(1'b1, 2'b11, 1'b1);
    checks++;
    if (dout !== 32'h0 || dout_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset: dout=%h valid=%b ovr=%b, want 0 0 0", dout, dout_valid, overrun);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ones();
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    for (int i = 0; i < 128; i++) begin
      cycle(1'b1, 2'b11, 1'b1);
      checks++;
      if (dout !== m_dout || dout_valid !== m_valid || overrun !== m_ovr) begin
        errors++;
        $display("FAIL ones cyc %0d: dout=%h v=%b o=%b, want %h %b %b",
                 i, dout, dout_valid, overrun, m_dout, m_valid, m_ovr);
      end
      if (dout_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        checks++;
        if (dout !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL ones_value cyc %0d: dout=%h, want ffffffff", i, dout);
        end
      end
    end
    checks++;
    if (pulses != 4 || first != 64) begin
      errors++;
      $display("FAIL ones_pulses: pulses=%0d first=%0d, want 4 64", pulses, first);
    end
  endtask

  task automatic test_alternating();
    do_reset(4'd4);
    for (int i = 0; i < 128; i++) begin
      cycle(1'b1, {1'b0, ~i[0]}, 1'b1);
      checks++;
      if (dout !== m_dout || dout_valid !== m_valid || overrun !== m_ovr) begin
        errors++;
        $display("FAIL alt cyc %0d: dout=%h v=%b o=%b, want %h %b %b",
                 i, dout, dout_valid, overrun, m_dout, m_valid, m_ovr);
      end
      if (dout_valid === 1'b1) begin
        checks++;
        if (dout !== 32'h0000_8000) begin
          errors++;
          $display("FAIL alt_value cyc %0d: dout=%h, want 00008000", i, dout);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(4'd4);
    for (int i = 0; i < 140; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), (i <= 64) || (i >= 97));
      checks++;
      if (dout !== m_dout || dout_valid !== m_valid || overrun !== m_ovr) begin
        errors++;
        $display("FAIL bp cyc %0d: dout=%h v=%b o=%b, want %h %b %b",
                 i, dout, dout_valid, overrun, m_dout, m_valid, m_ovr);
      end
      if (i == 79 || i == 80) begin
        checks++;
        if (overrun !== (i == 80) || dout_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_overrun cyc %0d: ovr=%b v=%b, want %b 1", i, overrun, dout_valid,
                   i == 80);
        end
      end
      if (i == 97) begin
        checks++;
        if (dout_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_drop: valid=%b, want 0", dout_valid);
        end
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_sticky: ovr=%b, want 1", overrun);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(4'd4);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), (i <= 64) || (i >= 80));
      checks++;
      if (dout !== m_dout || dout_valid !== m_valid || overrun !== m_ovr) begin
        errors++;
        $display("FAIL b2b cyc %0d: dout=%h v=%b o=%b, want %h %b %b",
                 i, dout, dout_valid, overrun, m_dout, m_valid, m_ovr);
      end
      if (i == 80 || i == 81) begin
        checks++;
        if (dout_valid !== (i == 80) || overrun !== 1'b0) begin
          errors++;
          $display("FAIL b2b_handshake cyc %0d: v=%b o=%b, want %b 0", i, dout_valid, overrun,
                   i == 80);
        end
      end
    end
  endtask

  task automatic test_flush();
    int pulses;
    int first;
    do_reset(4'd4);
    for (int i = 0; i < 70; i++) cycle(1'b1, 2'b11, 1'b1);
    log2_r = 4'd2;
    cycle(1'b0, 2'b11, 1'b1);
    checks++;
    if (dout !== m_dout || dout_valid !== m_valid || overrun !== m_ovr) begin
      errors++;
      $display("FAIL flush_hold: dout=%h v=%b o=%b, want %h %b %b",
               dout, dout_valid, overrun, m_dout, m_valid, m_ovr);
    end
    log2_r = 4'd7;
    pulses = 0;
    first  = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 2'b11, 1'b1);
      checks++;
      if (dout !== m_dout || dout_valid !== m_valid || overrun !== m_ovr) begin
        errors++;
        $display("FAIL flush cyc %0d: dout=%h v=%b o=%b, want %h %b %b",
                 i, dout, dout_valid, overrun, m_dout, m_valid, m_ovr);
      end
      if (dout_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        if (dout !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL flush_value cyc %0d: dout=%h, want ffffffff", i, dout);
        end
      end
    end
    checks++;
    if (pulses != 6 || first != 16) begin
      errors++;
      $display("FAIL flush_pulses: pulses=%0d first=%0d, want 6 16", pulses, first);
    end
  endtask

  task automatic test_clamp();
    int pulses;
    int first;
    do_reset(4'd0);
    pulses = 0;
    for (int i = 0; i < 21; i++) begin
      cycle(1'b1, 2'b11, 1'b1);
      if (dout_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 7 || dout !== m_dout || dout !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL clamp_low: pulses=%0d dout=%h, want 7 ffffffff", pulses, dout);
    end
    log2_r = 4'd15;
    cycle(1'b0, 2'b11, 1'b1);
    pulses = 0;
    first  = -1;
    for (int i = 0; i < 1100; i++) begin
      cycle(1'b1, 2'b11, 1'b1);
      checks++;
      if (dout !== m_dout || dout_valid !== m_valid || overrun !== m_ovr) begin
        errors++;
        $display("FAIL clamp_high cyc %0d: dout=%h v=%b o=%b, want %h %b %b",
                 i, dout, dout_valid, overrun, m_dout, m_valid, m_ovr);
      end
      if (dout_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (pulses != 1 || first != 1024) begin
      errors++;
      $display("FAIL clamp_high_pulses: pulses=%0d first=%0d, want 1 1024", pulses, first);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(4'd4);
    for (int i = 0; i < 90; i++) cycle(1'b1, 2'($urandom_range(0, 3)), i <= 64);
    checks++;
    if (dout_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: v=%b o=%b, want 1 1", dout_valid, overrun);
    end
    rst_n = 1'b0;
    cycle(1'b1, 2'b11, 1'b0);
    rst_n = 1'b1;
    checks++;
    if (dout !== 32'h0 || dout_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL rstmid: dout=%h v=%b o=%b, want 0 0 0", dout, dout_valid, overrun);
    end
    for (int i = 0; i < 80; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), 1'b1);
      checks++;
      if (dout !== m_dout || dout_valid !== m_valid || overrun !== m_ovr ||
          (dout_valid === 1'b1 && i < 64)) begin
        errors++;
        $display("FAIL rstmid_settle cyc %0d: dout=%h v=%b o=%b, want %h %b %b",
                 i, dout, dout_valid, overrun, m_dout, m_valid, m_ovr);
      end
    end
  endtask

  task automatic test_random();
    do_reset(4'd3);
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      checks++;
      if (dout !== m_dout || dout_valid !== m_valid || overrun !== m_ovr) begin
        errors++;
        $display("FAIL random cyc %0d: dout=%h v=%b o=%b, want %h %b %b",
                 i, dout, dout_valid, overrun, m_dout, m_valid, m_ovr);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    log2_r     = 4'd4;
    stream_in  = '0;
    dout_ready = 1'b1;
    test_reset();
    test_ones();
    test_alternating();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
